spi_reg_bank: RTL



---
 rtl/spi_reg_pkg.sv | 17 +
 rtl/spi_sync.sv | 31 +++
 rtl/spi_reg_bank.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/spi_reg_pkg.sv
// Shared types and frame-format constants for the SPI register bank.
package spi_reg_pkg;

  localparam int unsigned ADDR_W   = 7;
  localparam int unsigned CMD_BITS = 1 + ADDR_W;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    DONE
  } state_t;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchroniser followed by a one-flop edge detector for one async input.
module spi_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;
  assign fall  = ~sync & prev;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI-slave (mode 0, MSB first) register bank with atomic commit at frame end.
// Optional register read-back on CIPO is enabled by defining SPI_READ_EN.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int unsigned NUM_REGS = 5,
  parameter int unsigned DATA_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       SCLK,
  input  logic                       nCS,
  input  logic                       COPI,
  output logic                       CIPO,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  output logic                       wr_strobe,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);

  localparam int unsigned CNT_W = 6;

  logic sclk_level, sclk_rise, sclk_fall;
  logic ncs_level, ncs_rise, ncs_fall;
  logic copi_level, copi_rise, copi_fall;

  spi_sync u_sclk (.clk(clk), .rst_n(rst_n), .din(SCLK), .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync u_ncs  (.clk(clk), .rst_n(rst_n), .din(nCS),  .level(ncs_level),  .rise(ncs_rise),  .fall(ncs_fall));
  spi_sync u_copi (.clk(clk), .rst_n(rst_n), .din(COPI), .level(copi_level), .rise(copi_rise), .fall(copi_fall));

  state_t              state;
  logic [CNT_W-1:0]    bit_cnt;
  logic [CMD_BITS-1:0] cmd_sr;
  logic [DATA_W-1:0]   data_sr;
  logic                over_len;
  logic                rd_frame;

  logic [CMD_BITS-1:0] cmd_next;
  logic [DATA_W-1:0]   data_next;
  logic [ADDR_W-1:0]   addr;
  logic                addr_ok;
  logic                ignored;
  logic                do_commit;
  logic                do_err;

  logic unused_bits;
  assign unused_bits = &{1'b0, sclk_level, ncs_level, copi_rise, copi_fall, cmd_sr[CMD_BITS-1]};

  assign cmd_next  = {cmd_sr[CMD_BITS-2:0], copi_level};
  assign data_next = DATA_W'({data_sr, copi_level});
  assign addr      = cmd_sr[ADDR_W-1:0];
  assign addr_ok   = 32'(addr) < NUM_REGS;

  // The R/W bit is only known once the first bit of a frame has been sampled.
  always_comb begin
    ignored   = 1'b0;
    do_commit = 1'b0;
    do_err    = 1'b0;
`ifndef SPI_READ_EN
    ignored = rd_frame && (state != CMD || bit_cnt != '0);
`endif
    if (ncs_rise && !ignored) begin
      case (state)
        CMD, DATA: do_err = 1'b1;
        DONE: begin
          if (over_len || !addr_ok) do_err = 1'b1;
          else if (!rd_frame)       do_commit = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      cmd_sr    <= '0;
      data_sr   <= '0;
      over_len  <= 1'b0;
      rd_frame  <= 1'b0;
      regs_o    <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      frame_err <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      if (ncs_rise) begin
        state <= IDLE;
        if (do_commit) begin
          for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (addr == ADDR_W'(k)) regs_o[k*DATA_W +: DATA_W] <= data_sr;
          end
          wr_addr   <= addr;
          wr_strobe <= 1'b1;
        end
        if (do_err) frame_err <= 1'b1;
      end else if (ncs_fall) begin
        state    <= CMD;
        bit_cnt  <= '0;
        cmd_sr   <= '0;
        data_sr  <= '0;
        over_len <= 1'b0;
        rd_frame <= 1'b0;
      end else if (sclk_rise) begin
        case (state)
          CMD: begin
            cmd_sr <= cmd_next;
            if (bit_cnt == '0) rd_frame <= (copi_level == RW_READ);
            if (bit_cnt == CNT_W'(CMD_BITS - 1)) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          DATA: begin
            data_sr <= data_next;
            if (bit_cnt == CNT_W'(DATA_W - 1)) begin
              state   <= DONE;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          DONE:    over_len <= 1'b1;
          default: ;
        endcase
      end
    end
  end

`ifdef SPI_READ_EN
  logic [DATA_W-1:0] out_sr;
  logic [DATA_W-1:0] rd_word;
  logic              rd_load;

  always_comb begin
    rd_word = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (cmd_next[ADDR_W-1:0] == ADDR_W'(k)) rd_word = regs_o[k*DATA_W +: DATA_W];
    end
  end

  assign rd_load = sclk_rise && state == CMD && bit_cnt == CNT_W'(CMD_BITS - 1)
                   && cmd_next[CMD_BITS-1] == RW_READ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sr <= '0;
      CIPO   <= 1'b0;
    end else if (ncs_rise || ncs_fall) begin
      out_sr <= '0;
      CIPO   <= 1'b0;
    end else if (rd_load) begin
      out_sr <= (32'(cmd_next[ADDR_W-1:0]) < NUM_REGS) ? rd_word : '0;
    end else if (sclk_fall) begin
      if (state == DATA && rd_frame) begin
        CIPO   <= out_sr[DATA_W-1];
        out_sr <= out_sr << 1;
      end else begin
        CIPO <= 1'b0;
      end
    end
  end
`else
  assign CIPO = 1'b0;
`endif

endmodule
